// File: rtl/gtf_clk_pkg.sv
// Shared helpers for the GTF refclk monitor: constant clog2 and Gray-code
// conversions on a fixed-width word that callers cast to their own width.
package gtf_clk_pkg;

    localparam int GRAY_MAX_W = 32;

    typedef logic [GRAY_MAX_W-1:0] gray_word_t;

    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

    function automatic gray_word_t bin2gray(input gray_word_t bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic gray_word_t gray2bin(input gray_word_t gray);
        gray_word_t bin;
        bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gtf_clk_edge_counter.sv
// One refclk channel: free-running edge counter in the monitored domain, Gray-coded
// and carried into clk through a two-flop synchroniser, then decoded back to binary.
module gtf_clk_edge_counter
    import gtf_clk_pkg::*;
#(
    parameter int CNT_WIDTH = 20
) (
    input  logic                 mon_clk_i,
    input  logic                 clk_i,
    input  logic                 rstn_i,
    output logic [CNT_WIDTH-1:0] count_o
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic [CNT_WIDTH-1:0] gray_q;
    logic [CNT_WIDTH-1:0] gray_d;

    (* ASYNC_REG = "TRUE" *) logic [CNT_WIDTH-1:0] sync1_q;
    (* ASYNC_REG = "TRUE" *) logic [CNT_WIDTH-1:0] sync2_q;

    assign cnt_d  = cnt_q + CNT_WIDTH'(1);
    assign gray_d = CNT_WIDTH'(bin2gray(gray_word_t'(cnt_q)));

    always_ff @(posedge mon_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q  <= '0;
            gray_q <= '0;
        end else begin
            // NOTE: non-blocking, so gray_q encodes the pre-edge count whatever the statement order.
            cnt_q  <= cnt_d;
            gray_q <= gray_d;
        end
    end

    // Only one Gray bit moves per edge, so a sample caught mid-transition is off by at most one count.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= gray_q;
            sync2_q <= sync1_q;
        end
    end

    assign count_o = CNT_WIDTH'(gray2bin(gray_word_t'(sync2_q)));

endmodule

// File: rtl/system_gtf_clk_buffer_mon.sv
// GTF refclk buffer bank: buffers W differential refclks and, once per window of
// system clocks, measures each one and flags it in or out of a programmable band.
module system_gtf_clk_buffer_mon
    import gtf_clk_pkg::*;
#(
    parameter string      SIMULATION    = "false",
    parameter int         CLK_BUS_WIDTH = 8,
    parameter logic [2:0] BUFG_DIV      = 3'd0,
    parameter int         CNT_WIDTH     = 20,
    parameter int         WINDOW_CYCLES = (SIMULATION == "true") ? 1000 : 100000,
    localparam int        SEL_W         = (CLK_BUS_WIDTH > 1) ? clog2(CLK_BUS_WIDTH) : 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [CLK_BUS_WIDTH-1:0] SYNCE_CLK_LVDS_P,
    input  logic [CLK_BUS_WIDTH-1:0] SYNCE_CLK_LVDS_N,
    output logic [CLK_BUS_WIDTH-1:0] SYNCE_CLK_OUT,
    input  logic [CNT_WIDTH-1:0]     freq_lo,
    input  logic [CNT_WIDTH-1:0]     freq_hi,
    input  logic [SEL_W-1:0]         freq_sel,
    output logic [CNT_WIDTH-1:0]     freq_cnt,
    output logic [CLK_BUS_WIDTH-1:0] clk_ok,
    output logic                     meas_done
);

    localparam int              WC_W    = clog2(WINDOW_CYCLES);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(WINDOW_CYCLES - 1);

    logic [CLK_BUS_WIDTH-1:0][CNT_WIDTH-1:0] cur_cnt;
    logic [CLK_BUS_WIDTH-1:0][CNT_WIDTH-1:0] delta;
    logic [CLK_BUS_WIDTH-1:0][CNT_WIDTH-1:0] prev_q;
    logic [CLK_BUS_WIDTH-1:0][CNT_WIDTH-1:0] result_q;
    logic [CLK_BUS_WIDTH-1:0]                in_band;
    logic [CLK_BUS_WIDTH-1:0]                clk_ok_q;
    logic [CNT_WIDTH-1:0]                    sel_cnt;
    logic [CNT_WIDTH-1:0]                    freq_cnt_q;
    logic [WC_W-1:0]                         wc_q;
    logic                                    terminal;
    logic                                    primed_q;
    logic                                    meas_done_q;

    for (genvar i = 0; i < CLK_BUS_WIDTH; i++) begin : g_ch
        logic ibuf_clk;
        logic odiv2_q;

        // Behavioural IBUFDS_GTE4 with ODIV2 (refclk / 2) feeding BUFG_GT.
        assign ibuf_clk = SYNCE_CLK_LVDS_P[i] & ~SYNCE_CLK_LVDS_N[i];

        always_ff @(posedge ibuf_clk or negedge rstn) begin
            if (!rstn) odiv2_q <= 1'b0;
            else       odiv2_q <= ~odiv2_q;
        end

        if (BUFG_DIV == 3'd0) begin : g_nodiv
            assign SYNCE_CLK_OUT[i] = odiv2_q;
        end else begin : g_div
            localparam int HI_CNT = (int'(BUFG_DIV) + 2) / 2;
            logic [2:0] div_q;
            logic [2:0] div_d;
            logic       out_q;

            assign div_d = (div_q == BUFG_DIV) ? 3'd0 : div_q + 3'd1;

            always_ff @(posedge odiv2_q or negedge rstn) begin
                if (!rstn) begin
                    div_q <= '0;
                    out_q <= 1'b0;
                end else begin
                    div_q <= div_d;
                    out_q <= (int'(div_d) < HI_CNT);
                end
            end

            assign SYNCE_CLK_OUT[i] = out_q;
        end

        gtf_clk_edge_counter #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_edge_counter (
            .mon_clk_i (SYNCE_CLK_OUT[i]),
            .clk_i     (clk),
            .rstn_i    (rstn),
            .count_o   (cur_cnt[i])
        );
    end

    assign terminal = (wc_q == WC_LAST);

    // Modular subtraction keeps the delta correct across a counter wrap; an
    // inverted band (lo > hi) can never be satisfied, so every channel fails.
    always_comb begin
        for (int i = 0; i < CLK_BUS_WIDTH; i++) begin
            delta[i]   = cur_cnt[i] - prev_q[i];
            in_band[i] = (delta[i] >= freq_lo) && (delta[i] <= freq_hi);
        end
    end

    always_comb begin
        // NOTE: default first, so an out-of-range select cannot leave sel_cnt unassigned (no latch).
        sel_cnt = '0;
        for (int i = 0; i < CLK_BUS_WIDTH; i++) begin
            if (freq_sel == SEL_W'(i)) sel_cnt = result_q[i];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wc_q        <= '0;
            primed_q    <= 1'b0;
            meas_done_q <= 1'b0;
            clk_ok_q    <= '0;
            // NOTE: the per-channel count files are tiny, so they are reset with the rest of the state.
            prev_q      <= '0;
            result_q    <= '0;
            freq_cnt_q  <= '0;
        end else begin
            wc_q        <= terminal ? '0 : wc_q + WC_W'(1);
            meas_done_q <= terminal;
            primed_q    <= primed_q | terminal;
            freq_cnt_q  <= sel_cnt;
            if (terminal) begin
                prev_q   <= cur_cnt;
                result_q <= delta;
                clk_ok_q <= primed_q ? in_band : '0;
            end
        end
    end

    assign freq_cnt  = freq_cnt_q;
    assign clk_ok    = clk_ok_q;
    assign meas_done = meas_done_q;

endmodule

// File: tb/tb_system_gtf_clk_buffer_mon.sv
// Directed bench for the refclk monitor: three channels (ch0 ~161.13 MHz, ch1 156.25 MHz,
// ch2 held stopped), 1000-cycle windows of a 10 MHz clk, i.e. 100 us per window.
module tb_system_gtf_clk_buffer_mon;

    localparam int W           = 3;
    localparam int CNTW        = 16;
    localparam int WIN         = 1000;
    localparam int CLK_HALF    = 50000;   // ps, 10 MHz
    localparam int CH0_HALF    = 3103;    // ps, ~161.1328 MHz -> 80.567 MHz after ODIV2 -> 8056.7/window
    localparam int CH1_HALF    = 3200;    // ps, 156.25 MHz -> 78.125 MHz after ODIV2 -> 7812.5/window
    localparam int DONE_BUDGET = 2 * WIN + 10;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            ref0_p = 1'b0;
    logic            ref1_p = 1'b0;
    bit              ch0_en = 1'b1;
    bit              ch1_en = 1'b1;
    wire  [W-1:0]    lvds_p = {1'b0, ref1_p, ref0_p};
    wire  [W-1:0]    lvds_n = ~lvds_p;
    logic [W-1:0]    clk_out;
    logic [CNTW-1:0] freq_lo;
    logic [CNTW-1:0] freq_hi;
    logic [1:0]      freq_sel;
    logic [CNTW-1:0] freq_cnt;
    logic [W-1:0]    clk_ok;
    logic            meas_done;

    int n_checks = 0;
    int n_pass   = 0;

    system_gtf_clk_buffer_mon #(
        .SIMULATION    ("true"),
        .CLK_BUS_WIDTH (W),
        .BUFG_DIV      (3'd0),
        .CNT_WIDTH     (CNTW),
        .WINDOW_CYCLES (WIN)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .SYNCE_CLK_LVDS_P (lvds_p),
        .SYNCE_CLK_LVDS_N (lvds_n),
        .SYNCE_CLK_OUT    (clk_out),
        .freq_lo          (freq_lo),
        .freq_hi          (freq_hi),
        .freq_sel         (freq_sel),
        .freq_cnt         (freq_cnt),
        .clk_ok           (clk_ok),
        .meas_done        (meas_done)
    );

    initial forever #CLK_HALF clk = ~clk;
    initial forever begin #CH0_HALF; ref0_p = ch0_en ? ~ref0_p : 1'b0; end
    initial forever begin #CH1_HALF; ref1_p = ch1_en ? ~ref1_p : 1'b0; end

    initial begin
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog: bench still running after 80000 clk cycles");
        $fatal(1, "watchdog expired");
    end

    // Returns at the negedge on which meas_done is seen, with the number of negedges waited.
    task automatic wait_done(input string tag, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (meas_done !== 1'b1 && cycles < DONE_BUDGET);
        n_checks++;
        if (meas_done !== 1'b1) $display("FAIL %s_timeout: meas_done not seen after %0d cycles", tag, cycles);
        else n_pass++;
    endtask

    task automatic test_reset();
        rstn     = 1'b0;
        freq_lo  = 16'd8000;
        freq_hi  = 16'd8100;
        freq_sel = 2'd0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (clk_ok !== 3'b000) $display("FAIL reset_clk_ok: got %b, want 000", clk_ok); else n_pass++;
        n_checks++;
        if (freq_cnt !== 16'd0) $display("FAIL reset_freq_cnt: got %0d, want 0", freq_cnt); else n_pass++;
        n_checks++;
        if (meas_done !== 1'b0) $display("FAIL reset_meas_done: got %b, want 0", meas_done); else n_pass++;
        n_checks++;
        if (clk_out !== 3'b000) $display("FAIL reset_clk_out: got %b, want 000", clk_out); else n_pass++;
        rstn = 1'b1;
    endtask

    task automatic test_prime();
        int cyc;
        wait_done("prime1", cyc);
        n_checks++;
        if (cyc !== WIN) $display("FAIL prime_first_window_len: got %0d, want %0d", cyc, WIN); else n_pass++;
        n_checks++;
        if (clk_ok[0] !== 1'b0) $display("FAIL prime_clk_ok0_first: got %b, want 0", clk_ok[0]); else n_pass++;
        wait_done("prime2", cyc);
        n_checks++;
        if (clk_ok[0] !== 1'b1) $display("FAIL prime_clk_ok0_second: got %b, want 1", clk_ok[0]); else n_pass++;
        @(negedge clk);
        n_checks++;
        if (meas_done !== 1'b0) $display("FAIL meas_done_one_cycle: got %b, want 0", meas_done); else n_pass++;
        n_checks++;
        if (freq_cnt !== 16'd8056 && freq_cnt !== 16'd8057)
            $display("FAIL prime_freq_cnt0: got %0d, want 8056 or 8057", freq_cnt);
        else n_pass++;
    endtask

    task automatic test_ch1_band();
        freq_sel = 2'd1;
        @(negedge clk);
        n_checks++;
        if (freq_cnt !== 16'd7812 && freq_cnt !== 16'd7813)
            $display("FAIL ch1_freq_cnt: got %0d, want 7812 or 7813", freq_cnt);
        else n_pass++;
        n_checks++;
        if (clk_ok[1:0] !== 2'b01) $display("FAIL ch1_out_of_band: clk_ok[1:0] got %b, want 01", clk_ok[1:0]); else n_pass++;
        freq_sel = 2'd0;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        int cyc;
        for (int w = 0; w < 20; w++) begin
            wait_done("wrap", cyc);
            n_checks++;
            if (clk_ok[0] !== 1'b1) $display("FAIL wrap_clk_ok0 window %0d: got %b, want 1", w, clk_ok[0]); else n_pass++;
            @(negedge clk);
            n_checks++;
            if (freq_cnt !== 16'd8056 && freq_cnt !== 16'd8057)
                $display("FAIL wrap_delta window %0d: got %0d, want 8056 or 8057", w, freq_cnt);
            else n_pass++;
        end
    endtask

    task automatic test_stopped();
        int cyc;
        ch0_en = 1'b0;
        wait_done("stop1", cyc);
        n_checks++;
        if (clk_ok[0] !== 1'b0) $display("FAIL stop_clk_ok0: got %b, want 0", clk_ok[0]); else n_pass++;
        wait_done("stop2", cyc);
        @(negedge clk);
        n_checks++;
        if ($isunknown(freq_cnt) || freq_cnt > 16'd2) $display("FAIL stop_freq_cnt: got %0d, want <= 2", freq_cnt); else n_pass++;
        n_checks++;
        if (clk_ok[0] !== 1'b0) $display("FAIL stop_clk_ok0_full: got %b, want 0", clk_ok[0]); else n_pass++;
        ch0_en = 1'b1;
    endtask

    task automatic test_reset_mid_window();
        int cyc;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        wait_done("rmw_w1", cyc);
        wait_done("rmw_w2", cyc);
        n_checks++;
        if (clk_ok[0] !== 1'b1) $display("FAIL rmw_before_clk_ok0: got %b, want 1", clk_ok[0]); else n_pass++;
        repeat (500) @(negedge clk);
        rstn = 1'b0;
        #1;
        n_checks++;
        if (clk_ok !== 3'b000) $display("FAIL rmw_clk_ok_async: got %b, want 000", clk_ok); else n_pass++;
        n_checks++;
        if (freq_cnt !== 16'd0) $display("FAIL rmw_freq_cnt_async: got %0d, want 0", freq_cnt); else n_pass++;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        wait_done("rmw_a1", cyc);
        n_checks++;
        if (cyc !== WIN) $display("FAIL rmw_first_done_at: got %0d, want %0d", cyc, WIN); else n_pass++;
        n_checks++;
        if (clk_ok[0] !== 1'b0) $display("FAIL rmw_prime_clk_ok0: got %b, want 0", clk_ok[0]); else n_pass++;
        wait_done("rmw_a2", cyc);
        n_checks++;
        if (cyc !== WIN) $display("FAIL rmw_second_done_at: got %0d, want %0d", cyc, WIN); else n_pass++;
        n_checks++;
        if (clk_ok[0] !== 1'b1) $display("FAIL rmw_after_clk_ok0: got %b, want 1", clk_ok[0]); else n_pass++;
    endtask

    task automatic test_band_limits();
        int cyc;
        freq_lo = 16'd9000;
        freq_hi = 16'd8000;
        wait_done("inv", cyc);
        n_checks++;
        if (clk_ok !== 3'b000) $display("FAIL inverted_band: got %b, want 000", clk_ok); else n_pass++;
        freq_sel = 2'd3;
        @(negedge clk);
        n_checks++;
        if (freq_cnt !== 16'd0) $display("FAIL sel_out_of_range: got %0d, want 0", freq_cnt); else n_pass++;
        freq_sel = 2'd0;
        freq_lo  = 16'd0;
        freq_hi  = 16'd0;
        wait_done("zero", cyc);
        n_checks++;
        if (clk_ok !== 3'b100) $display("FAIL band_0_0_stopped_passes: got %b, want 100", clk_ok); else n_pass++;
        freq_lo = 16'd1;
        freq_hi = 16'd10;
        wait_done("lo1", cyc);
        n_checks++;
        if (clk_ok !== 3'b000) $display("FAIL band_1_10: got %b, want 000", clk_ok); else n_pass++;
        // Limits wander mid-window but are back in place before the terminal cycle.
        freq_lo = 16'd8000;
        freq_hi = 16'd8100;
        repeat (300) @(negedge clk);
        freq_lo = 16'd0;
        freq_hi = 16'd0;
        repeat (300) @(negedge clk);
        freq_lo = 16'd8000;
        freq_hi = 16'd8100;
        wait_done("midwin", cyc);
        n_checks++;
        if (clk_ok !== 3'b001) $display("FAIL limits_mid_window: got %b, want 001", clk_ok); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_prime();
        test_ch1_band();
        test_wrap();
        test_stopped();
        test_reset_mid_window();
        test_band_limits();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
